// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the FFT path: packs samples into a shift-register FIFO and
// bursts each full frame into the FFT core. It then waits for completion and clears the FIFO.
module fft_frame_sequencer #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned FRAME_LEN = 128,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  output logic              fifo_wr_ce,
  output logic              fifo_rd_ce,
  output logic              fifo_clr,
  output logic [DWIDTH-1:0] fifo_data_in,
  input  logic [DWIDTH-1:0] fifo_data_out,
  input  logic              fifo_error,
  output logic              fft_start,
  output logic              fft_in_valid,
  output logic [DWIDTH-1:0] fft_in_data,
  output logic              fft_in_last,
  input  logic              fft_done,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic              fault
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = 16;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_IDX  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {FILL, LOAD, WAIT_FFT, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          overrun_q, overrun_d;
  logic          fault_q, fault_d;
  logic          done_q, done_d;

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= FILL;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      fault_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      fault_q     <= fault_d;
      done_q      <= done_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    tcnt_d       = tcnt_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    fault_d      = fault_q;
    done_d       = done_q;
    s_ready      = 1'b0;
    fifo_wr_ce   = 1'b0;
    fifo_rd_ce   = 1'b0;
    fifo_clr     = 1'b0;
    fft_start    = 1'b0;
    fft_in_valid = 1'b0;
    fft_in_last  = 1'b0;
    fft_in_data  = '0;
    fifo_data_in = s_data;

    case (state_q)
      FILL: begin
        s_ready    = enable;
        fifo_wr_ce = s_valid && enable;
        if (s_valid && enable) begin
          if (wcnt_q == LAST_IDX) begin
            wcnt_d  = '0;
            state_d = LOAD;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      LOAD: begin
        fifo_rd_ce   = 1'b1;
        fft_in_valid = 1'b1;
        fft_in_data  = fifo_data_out;
        fft_start    = (rcnt_q == '0);
        fft_in_last  = (rcnt_q == LAST_IDX);
        if (rcnt_q == LAST_IDX) begin
          rcnt_d  = '0;
          tcnt_d  = '0;
          state_d = WAIT_FFT;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      WAIT_FFT: begin
        // Completion takes priority over a coincident timeout expiry
        if (fft_done) begin
          done_d  = 1'b1;
          state_d = CLEAR;
        end else if ((TIMEOUT != 0) && (tcnt_q == TMO_IDX)) begin
          done_d  = 1'b0;
          fault_d = 1'b1;
          state_d = CLEAR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      CLEAR: begin
        fifo_clr = 1'b1;
        if (done_q) frame_cnt_d = frame_cnt_q + 16'd1;
        done_d  = 1'b0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase

    if (s_valid && enable && (state_q != FILL)) overrun_d = 1'b1;
    if (fifo_error) fault_d = 1'b1;

    // Reset is synchronous, so strobes are forced low for the whole reset cycle
    if (!n_rst) begin
      s_ready      = 1'b0;
      fifo_wr_ce   = 1'b0;
      fifo_rd_ce   = 1'b0;
      fifo_clr     = 1'b0;
      fft_start    = 1'b0;
      fft_in_valid = 1'b0;
      fft_in_last  = 1'b0;
      fft_in_data  = '0;
    end
  end

  assign busy      = (state_q != FILL);
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;
  assign fault     = fault_q;

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
Sequences one 128-deep shift-register frame FIFO (fifo128_type2 style: wr_ce/rd_ce/fft_edone interface) around the FFT core in the noise-cancelling datapath. It:
- accepts a streaming audio sample input and packs FRAME_LEN samples into the FIFO;
- bursts the frame into the FFT core, then waits for FFT completion;
- clears the FIFO count and re-arms for the next frame.
It also owns the overrun, timeout and FIFO-error status reporting for the frame path.

Parameters:
DWIDTH, 32, sample and FIFO data width
FRAME_LEN, 128, samples per frame; must equal FIFO depth; range 2..128
TIMEOUT, 4096, max cycles in WAIT_FFT before fault; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  reset, synchronous, active-low
enable  in  1  permits acceptance of new samples
s_valid  in  1  input sample valid
s_data  in  DWIDTH  input sample
s_ready  out  1  sample accepted when s_valid&&s_ready
fifo_wr_ce  out  1  to FIFO wr_ce
fifo_rd_ce  out  1  to FIFO rd_ce
fifo_clr  out  1  to FIFO fft_edone (count clear)
fifo_data_in  out  DWIDTH  to FIFO data_in
fifo_data_out  in  DWIDTH  FIFO head word (combinational in FIFO)
fifo_error  in  1  FIFO error flag
fft_start  out  1  one-cycle pulse, first word of frame
fft_in_valid  out  1  FFT input word valid
fft_in_data  out  DWIDTH  FFT input word
fft_in_last  out  1  marks word FRAME_LEN-1
fft_done  in  1  FFT completion pulse
busy  out  1  high outside FILL
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
overrun  out  1  sticky: sample offered while not accepting
fault  out  1  sticky: timeout or fifo_error

Behaviour:
- Reset (n_rst=0 at posedge):
  - state=FILL; wcnt=rcnt=tcnt=0; frame_cnt=0; overrun=fault=0.
  - All registered outputs 0; s_ready=0 while n_rst=0.
  - Reset mid-frame aborts immediately; the FIFO is reset by the same n_rst.
- Counters: wcnt and rcnt 8 bits, tcnt 16 bits.
- FILL:
  - s_ready = enable (combinational). fifo_wr_ce = s_valid&&s_ready; fifo_data_in = s_data (combinational pass-through).
  - Each accept increments wcnt.
  - The accept with wcnt==FRAME_LEN-1 sets wcnt=0 and enters LOAD next cycle.
  - enable=0 holds wcnt (partial frame retained).
- LOAD, exactly FRAME_LEN consecutive cycles, no backpressure:
  - fifo_rd_ce=1, fft_in_valid=1, fft_in_data=fifo_data_out (combinational).
  - fft_start=1 when rcnt==0; fft_in_last=1 when rcnt==FRAME_LEN-1; rcnt increments each cycle.
  - After the last word: rcnt=0, tcnt=0, go to WAIT_FFT.
  - fifo_wr_ce=0 throughout, so the FIFO sees pure reads.
- WAIT_FFT:
  - fft_done=1 -> CLEAR.
  - Else tcnt increments. If TIMEOUT!=0 and tcnt==TIMEOUT-1 -> fault=1, go to CLEAR.
  - fft_done in the same cycle as timeout expiry: done wins, no fault.
- CLEAR, one cycle:
  - fifo_clr=1, fifo_wr_ce=0, fifo_rd_ce=0. This guarantees the FIFO count resets.
  - frame_cnt increments only if the exit from WAIT_FFT was via fft_done. Next state is FILL.
- fft_done outside WAIT_FFT: ignored.
- overrun: set when s_valid=1 && enable=1 && state!=FILL. Cleared only by reset.
- fault: set when fifo_error=1 in any state, or on timeout. Cleared only by reset.
- busy = (state!=FILL).
- fifo_wr_ce, fifo_rd_ce and fifo_clr are mutually exclusive in every cycle.
- Latency:
  - Last sample accept -> fft_start: 1 cycle.
  - fft_start -> fft_in_last: FRAME_LEN-1 cycles.
  - fft_done -> s_ready high again: 2 cycles (CLEAR, then FILL).

Test Plan:
- Reset, enable=1, feed samples 1..128 on consecutive cycles -> fifo_wr_ce high 128 cycles; fft_start 1 cycle after last accept; fft_in_data sequence 1..128; fft_in_last with 128; FIFO count returns to 0.
- After LOAD, pulse fft_done 10 cycles later -> fifo_clr high exactly 1 cycle; frame_cnt 0->1; s_ready=1 two cycles after fft_done.
- Hold s_valid=1 continuously through LOAD/WAIT_FFT -> overrun=1 and stays 1; no FIFO write occurs outside FILL.
- Feed 60 samples, drop enable for 20 cycles, feed 68 more -> a single frame of 128 words in order; fft_start only after sample 128.
- TIMEOUT=16, never assert fft_done -> fault=1 at cycle 16 of WAIT_FFT; CLEAR issued; frame_cnt unchanged; next frame proceeds normally.
- Assert n_rst=0 at rcnt=50 in LOAD -> all outputs 0, state FILL, frame_cnt=0; a full 128-sample frame afterwards completes correctly.
